// File: rtl/execute_stage_if.sv
// ID/EX operand bundle into the execute stage and EX/MEM-side results back out.
interface execute_stage_if;
    logic [3:0]  ALUControlIE;
    logic [1:0]  ALUSrcE;
    logic        RegDstE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [4:0]  RtE;
    logic [4:0]  RdE;
    logic [31:0] SignImmE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic [31:0] ALUOutM;
    logic [31:0] ALUOutE;
    logic [31:0] WriteDataE;
    logic [4:0]  WriteRegE;
    logic        StallMD;
    logic        BusyMD;

    // Pipeline side: drives the ID/EX register and forwarding selects.
    modport master (
        output ALUControlIE, ALUSrcE, RegDstE, RD1E, RD2E, RtE, RdE, SignImmE,
               ForwardAE, ForwardBE, ResultW, ALUOutM,
        input  ALUOutE, WriteDataE, WriteRegE, StallMD, BusyMD
    );

    // Execute stage side.
    modport slave (
        input  ALUControlIE, ALUSrcE, RegDstE, RD1E, RD2E, RtE, RdE, SignImmE,
               ForwardAE, ForwardBE, ResultW, ALUOutM,
        output ALUOutE, WriteDataE, WriteRegE, StallMD, BusyMD
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, and a 32-cycle shift-add multiplier
// owning HI/LO, with a stall request for dependent instructions while it runs.
module execute_stage (
    input  logic            clk,
    input  logic            inicio,
    execute_stage_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned CW = 6;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand;
    logic [DW-1:0]   mplier;
    logic [PW-1:0]   acc;
    logic            neg;
    logic [DW-1:0]   hi, lo;

    logic [DW-1:0]   src_a, fwd_b, src_b, alu_res;
    logic [4:0]      shamt;
    logic            is_mul, is_md, start, last_step;
    logic [DW-1:0]   a_mag, b_mag;
    logic [PW-1:0]   acc_step, product;

    // Forwarding muxes; select 11 falls back to the register-file operand.
    always_comb begin
        unique case (bus.ForwardAE)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = bus.ALUOutM;
            default: src_a = bus.RD1E;
        endcase
        unique case (bus.ForwardBE)
            2'b01:   fwd_b = bus.ResultW;
            2'b10:   fwd_b = bus.ALUOutM;
            default: fwd_b = bus.RD2E;
        endcase
    end

    // SrcB select and shift amount source.
    always_comb begin
        unique case (bus.ALUSrcE)
            2'b00:   src_b = fwd_b;
            2'b01:   src_b = bus.SignImmE;
            2'b10:   src_b = {27'b0, bus.SignImmE[10:6]};
            default: src_b = {16'b0, bus.SignImmE[15:0]};
        endcase
        shamt = (bus.ALUSrcE == 2'b10) ? bus.SignImmE[10:6] : src_a[4:0];
    end

    // ALU proper; multiply issue reports zero, MFHI/MFLO read the product registers.
    always_comb begin
        alu_res = '0;
        unique case (bus.ALUControlIE)
            OP_AND:   alu_res = src_a & src_b;
            OP_OR:    alu_res = src_a | src_b;
            OP_ADD:   alu_res = src_a + src_b;
            OP_XOR:   alu_res = src_a ^ src_b;
            OP_NOR:   alu_res = ~(src_a | src_b);
            OP_SLL:   alu_res = fwd_b << shamt;
            OP_SUB:   alu_res = src_a - src_b;
            OP_SLT:   alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
            OP_SRL:   alu_res = fwd_b >> shamt;
            OP_SRA:   alu_res = DW'($signed(fwd_b) >>> shamt);
            OP_LUI:   alu_res = {src_b[15:0], 16'b0};
            OP_SLTU:  alu_res = {31'b0, src_a < src_b};
            OP_MFHI:  alu_res = hi;
            OP_MFLO:  alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    assign bus.ALUOutE    = alu_res;
    assign bus.WriteDataE = fwd_b;
    assign bus.WriteRegE  = bus.RegDstE ? bus.RdE : bus.RtE;

    // Multiplier issue decode, operand magnitudes and the shift-add step.
    always_comb begin
        is_mul    = (bus.ALUControlIE == OP_MULT) || (bus.ALUControlIE == OP_MULTU);
        is_md     = is_mul || (bus.ALUControlIE == OP_MFHI) || (bus.ALUControlIE == OP_MFLO);
        start     = (state == S_IDLE) && is_mul;
        last_step = (state == S_RUN) && (cnt == CW'(1));
        a_mag     = src_a;
        b_mag     = fwd_b;
        if (bus.ALUControlIE == OP_MULT) begin
            if (src_a[DW-1]) a_mag = DW'(-src_a);
            if (fwd_b[DW-1]) b_mag = DW'(-fwd_b);
        end
        acc_step = mplier[0] ? PW'(acc + mcand) : acc;
        product  = neg ? PW'(-acc_step) : acc_step;
    end

    assign bus.BusyMD  = (state == S_RUN);
    assign bus.StallMD = (state == S_RUN) && is_md;

    // Multiplier state register.
    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Multiplier next-state: run for exactly the programmed step count.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start)     state_nxt = S_RUN;
            S_RUN:   if (last_step) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Multiplier datapath and HI/LO; reset aborts without touching HI/LO contents beyond clearing.
    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (start) begin
            cnt    <= CW'(DW);
            mcand  <= {{DW{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= (bus.ALUControlIE == OP_MULT) && (src_a[DW-1] ^ fwd_b[DW-1]);
        end else if (state == S_RUN) begin
            cnt    <= cnt - CW'(1);
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last_step) begin
                hi <= product[PW-1:DW];
                lo <= product[DW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; stimulus queues expectations, a negedge monitor checks them.
module tb_execute_stage;
    logic clk = 1'b0;
    logic inicio;
    always #5 clk = ~clk;

    execute_stage_if bus ();
    execute_stage dut (.clk(clk), .inicio(inicio), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wreg;
        logic        stall;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [3:0] AND_ = 4'h0, OR_ = 4'h1, ADD_ = 4'h2, NOR_ = 4'h4, SLL_ = 4'h5,
                           SUB_ = 4'h6, SLT_ = 4'h7, SRL_ = 4'h8, SRA_ = 4'h9, LUI_ = 4'hA,
                           SLTU_ = 4'hB, MULT_ = 4'hC, MULTU_ = 4'hD, MFHI_ = 4'hE, MFLO_ = 4'hF;

    task automatic drive(input logic [3:0] c, input logic [1:0] s, input logic rdst,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [1:0] fa, input logic [1:0] fb);
        bus.ALUControlIE = c;
        bus.ALUSrcE      = s;
        bus.RegDstE      = rdst;
        bus.RD1E         = a;
        bus.RD2E         = b;
        bus.SignImmE     = imm;
        bus.ForwardAE    = fa;
        bus.ForwardBE    = fb;
        bus.RtE          = 5'd3;
        bus.RdE          = 5'd17;
        bus.ResultW      = 32'd3;
        bus.ALUOutM      = 32'd9;
    endtask

    task automatic expect_out(input string n, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] wreg, input logic stall, input logic busy);
        exp_t x;
        x.name = n; x.alu = alu; x.wd = wd; x.wreg = wreg; x.stall = stall; x.busy = busy;
        sb.push_back(x);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.ALUOutE !== e.alu || bus.WriteDataE !== e.wd || bus.WriteRegE !== e.wreg ||
                bus.StallMD !== e.stall || bus.BusyMD !== e.busy) begin
                n_bad++;
                $display("FAIL %s: got alu=%h wd=%h wreg=%0d stall=%b busy=%b, want alu=%h wd=%h wreg=%0d stall=%b busy=%b",
                         e.name, bus.ALUOutE, bus.WriteDataE, bus.WriteRegE, bus.StallMD, bus.BusyMD,
                         e.alu, e.wd, e.wreg, e.stall, e.busy);
            end
        end
    end

    initial begin
        inicio = 1'b1;
        drive(AND_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        step;
        expect_out("reset_bubble", 32'h0, 32'h0, 5'd3, 1'b0, 1'b0);
        step;
        inicio = 1'b0;

        // Plain ALU operations
        drive(ADD_, 2'b00, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 2'b00, 2'b00);
        expect_out("add_wrap", 32'h80000000, 32'd1, 5'd3, 1'b0, 1'b0);
        step;
        drive(SUB_, 2'b00, 1'b0, 32'd0, 32'd1, 32'd0, 2'b00, 2'b00);
        expect_out("sub_wrap", 32'hFFFFFFFF, 32'd1, 5'd3, 1'b0, 1'b0);
        step;
        drive(SLT_, 2'b00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 2'b00, 2'b00);
        expect_out("slt_signed", 32'd1, 32'd1, 5'd3, 1'b0, 1'b0);
        step;
        drive(SLTU_, 2'b00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 2'b00, 2'b00);
        expect_out("sltu", 32'd0, 32'd1, 5'd3, 1'b0, 1'b0);
        step;
        drive(SRA_, 2'b10, 1'b0, 32'd0, 32'h80000000, 32'h00000100, 2'b00, 2'b00);
        expect_out("sra_shamt4", 32'hF8000000, 32'h80000000, 5'd3, 1'b0, 1'b0);
        step;
        drive(SRL_, 2'b10, 1'b0, 32'd0, 32'h80000000, 32'h00000100, 2'b00, 2'b00);
        expect_out("srl_shamt4", 32'h08000000, 32'h80000000, 5'd3, 1'b0, 1'b0);
        step;
        drive(SLL_, 2'b00, 1'b0, 32'd4, 32'd1, 32'd0, 2'b00, 2'b00);
        expect_out("sll_by_srca", 32'h10, 32'd1, 5'd3, 1'b0, 1'b0);
        step;
        drive(LUI_, 2'b11, 1'b0, 32'd0, 32'd0, 32'hFFFF1234, 2'b00, 2'b00);
        expect_out("lui_zext", 32'h12340000, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        drive(NOR_, 2'b00, 1'b0, 32'h0F0F0000, 32'h000000F0, 32'd0, 2'b00, 2'b00);
        expect_out("nor", 32'hF0F0FF0F, 32'h000000F0, 5'd3, 1'b0, 1'b0);
        step;

        // Forwarding paths and destination select
        drive(ADD_, 2'b01, 1'b0, 32'd5, 32'd0, 32'd1, 2'b10, 2'b00);
        expect_out("fwd_a_mem", 32'd10, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        drive(ADD_, 2'b01, 1'b1, 32'd5, 32'd0, 32'd1, 2'b01, 2'b00);
        expect_out("fwd_a_wb_rd", 32'd4, 32'd0, 5'd17, 1'b0, 1'b0);
        step;
        drive(ADD_, 2'b01, 1'b0, 32'd5, 32'd0, 32'd1, 2'b11, 2'b00);
        expect_out("fwd_a_11", 32'd6, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        drive(SUB_, 2'b00, 1'b0, 32'd20, 32'd1, 32'd0, 2'b00, 2'b10);
        expect_out("fwd_b_mem", 32'd11, 32'd9, 5'd3, 1'b0, 1'b0);
        step;
        drive(SUB_, 2'b00, 1'b0, 32'd20, 32'd1, 32'd0, 2'b00, 2'b01);
        expect_out("fwd_b_wb", 32'd17, 32'd3, 5'd3, 1'b0, 1'b0);
        step;

        // Signed multiply with independent work during the run
        drive(MULT_, 2'b00, 1'b0, 32'hFFFFFFFD, 32'd7, 32'd0, 2'b00, 2'b00);
        expect_out("mult_issue", 32'd0, 32'd7, 5'd3, 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            step;
            drive(OR_, 2'b00, 1'b0, 32'hF0, 32'h0F, 32'd0, 2'b00, 2'b00);
            expect_out($sformatf("or_during_run_%0d", i), 32'hFF, 32'h0F, 5'd3, 1'b0, 1'b1);
        end
        step;
        drive(MFHI_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        expect_out("mfhi_neg21", 32'hFFFFFFFF, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        drive(MFLO_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        expect_out("mflo_neg21", 32'hFFFFFFEB, 32'd0, 5'd3, 1'b0, 1'b0);
        step;

        // Unsigned multiply with a dependent MFLO stalled behind it
        drive(MULTU_, 2'b00, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 2'b00, 2'b00);
        expect_out("multu_issue", 32'd0, 32'd2, 5'd3, 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            step;
            drive(MFLO_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
            expect_out($sformatf("mflo_stall_%0d", i), 32'hFFFFFFEB, 32'd0, 5'd3, 1'b1, 1'b1);
        end
        step;
        drive(MFLO_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        expect_out("mflo_after_stall", 32'hFFFFFFFE, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        drive(MFHI_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        expect_out("mfhi_multu", 32'd1, 32'd0, 5'd3, 1'b0, 1'b0);
        step;

        // Reset in the middle of a run
        drive(MULT_, 2'b00, 1'b0, 32'd3, 32'd5, 32'd0, 2'b00, 2'b00);
        expect_out("mult_issue2", 32'd0, 32'd5, 5'd3, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step;
            drive(OR_, 2'b00, 1'b0, 32'h1, 32'h2, 32'd0, 2'b00, 2'b00);
            expect_out($sformatf("or_run2_%0d", i), 32'h3, 32'h2, 5'd3, 1'b0, 1'b1);
        end
        step;
        inicio = 1'b1;
        drive(MFHI_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        expect_out("abort_in_reset", 32'd0, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        inicio = 1'b0;
        drive(MFHI_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        expect_out("mfhi_after_abort", 32'd0, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        drive(MFLO_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);
        expect_out("mflo_after_abort", 32'd0, 32'd0, 5'd3, 1'b0, 1'b0);
        step;
        drive(AND_, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) step;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the five-stage MIPS pipeline. Consumes the ID/EX pipeline register outputs, applies the operand forwarding selected by the hazard unit and computes the ALU result and destination register for the EX/MEM latch. Contains a 32-cycle iterative multiplier with HI/LO registers and raises a stall request when a dependent instruction reaches EX while the multiplier is busy.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  rising-edge clock
- inicio  in  1  asynchronous active-high reset
- ALUControlIE  in  4  operation code (encoding in Operation)
- ALUSrcE  in  2  SrcB select: 00 forwarded RD2, 01 SignImmE, 10 shamt, 11 zero-extended imm
- RegDstE  in  1  1 selects RdE, 0 selects RtE
- RD1E, RD2E  in  32  register operands from ID/EX
- RtE, RdE  in  5  destination candidates
- SignImmE  in  32  sign-extended immediate
- ForwardAE, ForwardBE  in  2  00 RDxE, 01 ResultW, 10 ALUOutM, 11 treated as 00
- ResultW  in  32  writeback-stage result
- ALUOutM  in  32  memory-stage ALU result
- ALUOutE  out  32  result to EX/MEM
- WriteDataE  out  32  forwarded B operand (store data)
- WriteRegE  out  5  destination register index
- StallMD  out  1  stall request to hazard unit (freeze F, D and ID/EX)
- BusyMD  out  1  multiplier running

## Operation
- SrcA = forward mux A; FwdB = forward mux B; WriteDataE = FwdB.
- SrcB: 00 FwdB, 01 SignImmE, 10 {27'b0, SignImmE[10:6]}, 11 {16'b0, SignImmE[15:0]}.
- WriteRegE = RegDstE ? RdE : RtE. All of the above combinational.
- ALUControlIE: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLL, 0110 SUB, 0111 SLT (signed), 1000 SRL, 1001 SRA, 1010 LUI ({SrcB[15:0],16'b0}), 1011 SLTU, 1100 MULT, 1101 MULTU, 1110 MFHI, 1111 MFLO.
- ADD/SUB wrap modulo 2^32, no overflow trap. SLT/SLTU produce 32'd1 or 32'd0.
- Shifts: value = FwdB; amount = SignImmE[10:6] when ALUSrcE=10, else SrcA[4:0].
- MULT/MULTU/MFHI/MFLO: ALUOutE = HI (MFHI), LO (MFLO), 0 (MULT/MULTU).
- Multiplier states IDLE, RUN; 6-bit counter.
  - IDLE + MULT/MULTU in EX: capture SrcA, FwdB (magnitudes for MULT, plus result-sign flag), counter=32, go RUN.
  - RUN: one shift-add step per cycle, counter decrements; on the step where counter goes 1->0, HI:LO <= 64-bit product (two's-complement negated when sign flag set), go IDLE.
- BusyMD = (state==RUN).
- StallMD = BusyMD & ALUControlIE in {MULT, MULTU, MFHI, MFLO}; combinational. A stalled MULT held in EX starts on the first cycle BusyMD is low. Independent instructions proceed during RUN.
- Flushed bubble (all-zero ID/EX) executes as AND with RegWrite low; no side effects.

## Timing
- Reset (inicio=1, any time): HI=0, LO=0, state IDLE, counter 0, BusyMD=0, StallMD=0; a running multiply is aborted and HI/LO not written. Combinational outputs follow inputs during reset.
- MULT in EX during cycle t (IDLE): operands captured at edge ending t; BusyMD=1 cycles t+1..t+32; HI/LO valid from cycle t+33.
- MFHI/MFLO/MULT in EX during t+1..t+32: StallMD=1; first non-stalled cycle is t+33 and it sees new HI/LO.
- Forwarding and ALU path: zero-cycle (combinational) to ALUOutE.
- ForwardAE/BE=11: treated as 00.

## Test plan
- ADD, RD1E=0x7FFFFFFF, RD2E=1, ForwardAE/BE=00, ALUSrcE=00 -> ALUOutE=0x80000000; SUB 0-1 -> 0xFFFFFFFF.
- SLT with SrcA=0xFFFFFFFF, SrcB=1 -> 1; SLTU same operands -> 0; SRA of FwdB=0x80000000 by shamt 4 (ALUSrcE=10) -> 0xF8000000.
- Forwarding: RD1E=5, ALUOutM=9, ResultW=3, ForwardAE=10, ADD with imm 1 (ALUSrcE=01) -> 10; ForwardAE=01 -> 4; RegDstE=1, RdE=17 -> WriteRegE=17.
- MULT 0xFFFFFFFD x 7 (-3*7) -> BusyMD high 32 cycles; then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFEB; MULTU 0xFFFFFFFF x 2 -> HI=1, LO=0xFFFFFFFE.
- MFLO presented cycle after MULT issue -> StallMD=1 for exactly 32 cycles, then ALUOutE = new LO; unrelated OR during RUN -> StallMD=0, correct result.
- Assert inicio at RUN cycle 10 -> BusyMD=0 immediately, HI=LO=0; subsequent MFHI returns 0 with no stall.
